// File: rtl/rx_sync_defs.sv
// Shared definitions for the Rx synchronisation controller: state codes,
// default timing parameters and the signal-loss window helper.
package rx_sync_defs;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_SEARCH   = 3'd2,
    S_PREAMBLE = 3'd3,
    S_ALIGN    = 3'd4,
    S_LOCKED   = 3'd5
  } state_t;

  localparam int unsigned FLUSH_CYCLES_DEF = 32;
  localparam int unsigned PD_TIMEOUT_DEF   = 65536;
  localparam int unsigned BD_TIMEOUT_DEF   = 65536;
  localparam int unsigned SD_LOSS_DEF      = 512;
  localparam int unsigned DWELL_W          = 20;

  // States in which a sustained SD_flag drop counts as loss of signal.
  function automatic logic in_loss_window(input state_t s);
    return s inside {S_PREAMBLE, S_ALIGN, S_LOCKED};
  endfunction

endpackage

// File: rtl/rx_sync_loss_det.sv
// Consecutive-low run counter on SD_flag; loss fires on the cycle the run
// reaches SD_LOSS. The run is held at zero while clear is high.
module rx_sync_loss_det
  import rx_sync_defs::*;
#(
  parameter int unsigned SD_LOSS = SD_LOSS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sd_flag,
  output logic loss
);

  localparam int unsigned CW = $clog2(SD_LOSS + 1);
  localparam logic [CW-1:0] LAST = CW'(SD_LOSS - 1);

  logic [CW-1:0] run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= '0;
    end else if (clear || sd_flag) begin
      run <= '0;
    end else if (run != LAST) begin
      run <= run + CW'(1);
    end
  end

  assign loss = !clear && !sd_flag && (run == LAST);

endmodule

// File: rtl/rx_sync_ctrl.sv
// Rx link synchronisation controller: flush, search, preamble, align, lock,
// with dwell timeouts, signal-loss recovery and frame/relock statistics.
module rx_sync_ctrl
  import rx_sync_defs::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned PD_TIMEOUT   = PD_TIMEOUT_DEF,
  parameter int unsigned BD_TIMEOUT   = BD_TIMEOUT_DEF,
  parameter int unsigned SD_LOSS      = SD_LOSS_DEF
) (
  input  logic        clk_32M768,
  input  logic        rst_n_32M768,
  input  logic        enable,
  input  logic        SD_flag,
  input  logic        PD_flag,
  input  logic        BD_flag,
  input  logic        BD_sgn,
  input  logic        rx_data_tvalid,
  input  logic        rx_data_tlast,
  output logic        rx_chain_rst_n,
  output logic        rx_gate,
  output logic        polarity_inv,
  output logic        lock,
  output logic [2:0]  state,
  output logic [15:0] frame_cnt,
  output logic [7:0]  relock_cnt,
  output logic        err_timeout
);

  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0]      FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [DWELL_W-1:0] PD_LAST    = DWELL_W'(PD_TIMEOUT - 1);
  localparam logic [DWELL_W-1:0] BD_LAST    = DWELL_W'(BD_TIMEOUT - 1);

  state_t             st;
  state_t             nxt;
  logic [DWELL_W-1:0] dwell;
  logic [FW-1:0]      flush_cnt;
  logic               loss;
  logic               loss_clear;
  logic               timeout_hit;

  assign loss_clear = !in_loss_window(st);

  rx_sync_loss_det #(
    .SD_LOSS(SD_LOSS)
  ) u_loss_det (
    .clk     (clk_32M768),
    .rst_n   (rst_n_32M768),
    .clear   (loss_clear),
    .sd_flag (SD_flag),
    .loss    (loss)
  );

  // Priority: enable low, then signal loss, then advance flag, then timeout.
  always_comb begin
    nxt         = st;
    timeout_hit = 1'b0;
    if (!enable) begin
      nxt = S_IDLE;
    end else if (loss) begin
      nxt = S_FLUSH;
    end else begin
      case (st)
        S_IDLE:   nxt = S_FLUSH;
        S_FLUSH:  if (flush_cnt == FLUSH_LAST) nxt = S_SEARCH;
        S_SEARCH: if (SD_flag) nxt = S_PREAMBLE;
        S_PREAMBLE: begin
          if (PD_flag) begin
            nxt = S_ALIGN;
          end else if (dwell == PD_LAST) begin
            nxt         = S_FLUSH;
            timeout_hit = 1'b1;
          end
        end
        S_ALIGN: begin
          if (BD_flag) begin
            nxt = S_LOCKED;
          end else if (dwell == BD_LAST) begin
            nxt         = S_FLUSH;
            timeout_hit = 1'b1;
          end
        end
        S_LOCKED: nxt = S_LOCKED;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      st             <= S_IDLE;
      dwell          <= '0;
      flush_cnt      <= '0;
      rx_chain_rst_n <= 1'b0;
      rx_gate        <= 1'b0;
      lock           <= 1'b0;
      polarity_inv   <= 1'b0;
      err_timeout    <= 1'b0;
      frame_cnt      <= '0;
      relock_cnt     <= '0;
    end else begin
      st <= nxt;

      if (nxt != st) begin
        dwell <= '0;
      end else if (st == S_PREAMBLE || st == S_ALIGN) begin
        dwell <= dwell + DWELL_W'(1);
      end

      if (nxt != st) begin
        flush_cnt <= '0;
      end else if (st == S_FLUSH) begin
        flush_cnt <= flush_cnt + FW'(1);
      end

      rx_chain_rst_n <= nxt inside {S_SEARCH, S_PREAMBLE, S_ALIGN, S_LOCKED};
      rx_gate        <= (nxt == S_LOCKED);
      lock           <= (nxt == S_LOCKED);
      err_timeout    <= timeout_hit;

      if (st == S_ALIGN && nxt == S_LOCKED) begin
        polarity_inv <= BD_sgn;
      end

      if (nxt == S_FLUSH && st != S_FLUSH) begin
        frame_cnt <= '0;
      end else if (st == S_LOCKED && rx_data_tvalid && rx_data_tlast && frame_cnt != '1) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (enable && loss && st == S_LOCKED && relock_cnt != '1) begin
        relock_cnt <= relock_cnt + 8'd1;
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Directed bench for rx_sync_ctrl: a cycle model built on time-in-state and
// low-run counts is compared every cycle, plus hand-computed milestones.
module tb_rx_sync_ctrl;

  localparam int FC  = 32;
  localparam int PDT = 300;
  localparam int BDT = 400;
  localparam int SDL = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        SD_flag, PD_flag, BD_flag, BD_sgn;
  logic        rx_data_tvalid, rx_data_tlast;
  logic        rx_chain_rst_n, rx_gate, polarity_inv, lock, err_timeout;
  logic [2:0]  state;
  logic [15:0] frame_cnt;
  logic [7:0]  relock_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  rx_sync_ctrl #(
    .FLUSH_CYCLES(FC),
    .PD_TIMEOUT  (PDT),
    .BD_TIMEOUT  (BDT),
    .SD_LOSS     (SDL)
  ) dut (
    .clk_32M768     (clk),
    .rst_n_32M768   (rst_n),
    .enable         (enable),
    .SD_flag        (SD_flag),
    .PD_flag        (PD_flag),
    .BD_flag        (BD_flag),
    .BD_sgn         (BD_sgn),
    .rx_data_tvalid (rx_data_tvalid),
    .rx_data_tlast  (rx_data_tlast),
    .rx_chain_rst_n (rx_chain_rst_n),
    .rx_gate        (rx_gate),
    .polarity_inv   (polarity_inv),
    .lock           (lock),
    .state          (state),
    .frame_cnt      (frame_cnt),
    .relock_cnt     (relock_cnt),
    .err_timeout    (err_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ms = state code, tin = full cycles already spent in ms,
  // lowrun = consecutive SD-low cycles inside the loss window.
  int ms = 0, tin = 0, lowrun = 0, frames = 0, relocks = 0;
  bit pol = 1'b0, err = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int nx;
    int run_now;
    bit lost;
    bit to_hit;
    if (!rst_n) begin
      ms = 0; tin = 0; lowrun = 0; frames = 0; relocks = 0; pol = 1'b0; err = 1'b0;
    end else begin
      run_now = (ms >= 3 && ms <= 5 && !SD_flag) ? lowrun + 1 : 0;
      lost    = (run_now >= SDL);
      nx      = ms;
      to_hit  = 1'b0;
      if (!enable) nx = 0;
      else if (lost) nx = 1;
      else begin
        case (ms)
          0: nx = 1;
          1: if (tin + 1 == FC) nx = 2;
          2: if (SD_flag) nx = 3;
          3: if (PD_flag) nx = 4; else if (tin + 1 == PDT) begin nx = 1; to_hit = 1'b1; end
          4: if (BD_flag) nx = 5; else if (tin + 1 == BDT) begin nx = 1; to_hit = 1'b1; end
          5: nx = 5;
          default: nx = 0;
        endcase
      end
      if (ms == 5 && enable && lost && relocks < 255) relocks++;
      if (ms == 4 && nx == 5) pol = BD_sgn;
      if (nx == 1 && ms != 1) frames = 0;
      else if (ms == 5 && rx_data_tvalid && rx_data_tlast && frames < 65535) frames++;
      lowrun = run_now;
      tin    = (nx != ms) ? 0 : tin + 1;
      err    = to_hit;
      ms     = nx;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cycle",
            {state, rx_chain_rst_n, rx_gate, lock, polarity_inv, err_timeout, frame_cnt, relock_cnt},
            {3'(ms), (ms >= 2 && ms <= 5), (ms == 5), (ms == 5), pol, err, 16'(frames), 8'(relocks)});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int code, input int budget);
    int n = 0;
    while (32'(state) != code && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", 32'(state), code);
  endtask

  task automatic measure_flush(input string name);
    int n = 0;
    while (!rx_chain_rst_n && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, n, FC);
    check("state_after_flush", 32'(state), 2);
  endtask

  task automatic measure_timeout(input string name, input int expect_len);
    int n = 0;
    while (!err_timeout && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, n, expect_len);
    check("state_after_timeout", 32'(state), 1);
    @(negedge clk);
    check("err_single_pulse", 32'(err_timeout), 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0;
    SD_flag = 1'b0; PD_flag = 1'b0; BD_flag = 1'b0; BD_sgn = 1'b0;
    rx_data_tvalid = 1'b0; rx_data_tlast = 1'b0;
    cyc(3);
    chk_on = 1'b1;
    check("reset_state",
          {state, rx_chain_rst_n, rx_gate, lock, polarity_inv, err_timeout, frame_cnt, relock_cnt}, 0);

    rst_n = 1'b1; enable = 1'b1;
    cyc(1);
    check("flush_entry", 32'(state), 1);
    measure_flush("flush_len");

    SD_flag = 1'b1;
    cyc(1);
    check("preamble_entry", 32'(state), 3);
    cyc(99);
    PD_flag = 1'b1; cyc(1); PD_flag = 1'b0;
    check("align_entry", 32'(state), 4);
    cyc(199);
    BD_flag = 1'b1; BD_sgn = 1'b1; cyc(1); BD_flag = 1'b0; BD_sgn = 1'b0;
    check("locked_state", {29'd0, state}, 5);
    check("lock_gate_pol", {lock, rx_gate, polarity_inv}, 3'b111);
    cyc(1);
    check("pol_hold", 32'(polarity_inv), 1);

    for (int i = 0; i < 3; i++) begin
      rx_data_tvalid = 1'b1; rx_data_tlast = 1'b1; cyc(1);
      rx_data_tvalid = 1'b0; rx_data_tlast = 1'b0; cyc(1);
    end
    rx_data_tvalid = 1'b1; cyc(1); rx_data_tvalid = 1'b0;
    rx_data_tlast = 1'b1; cyc(1); rx_data_tlast = 1'b0;
    check("frames_before_loss", 32'(frame_cnt), 3);

    SD_flag = 1'b0;
    cyc(SDL - 1);
    check("no_loss_at_511", 32'(state), 5);
    cyc(1);
    check("loss_to_flush", 32'(state), 1);
    check("relock_cnt", 32'(relock_cnt), 1);
    check("frame_cleared", 32'(frame_cnt), 0);
    SD_flag = 1'b1;

    wait_state(3, 100);
    measure_timeout("pd_timeout_len", PDT);

    wait_state(3, 100);
    cyc(PDT - 1);
    PD_flag = 1'b1; cyc(1); PD_flag = 1'b0;
    check("pd_at_expiry_state", 32'(state), 4);
    check("pd_at_expiry_err", 32'(err_timeout), 0);
    measure_timeout("bd_timeout_len", BDT);

    wait_state(3, 100);
    PD_flag = 1'b1; cyc(1); PD_flag = 1'b0;
    BD_flag = 1'b1; BD_sgn = 1'b0; cyc(1); BD_flag = 1'b0;
    check("relock_state", 32'(state), 5);
    check("pol_relatch", 32'(polarity_inv), 0);

    SD_flag = 1'b0; cyc(SDL - 1); SD_flag = 1'b1; cyc(2);
    check("glitch_no_loss", {state, relock_cnt}, {3'd5, 8'd1});

    enable = 1'b0; cyc(1);
    check("disable_from_locked", {state, lock, rx_chain_rst_n}, {3'd0, 1'b0, 1'b0});
    enable = 1'b1; cyc(1);
    check("reenable_flush", 32'(state), 1);
    cyc(10);
    enable = 1'b0; cyc(1);
    check("flush_abort", 32'(state), 0);
    enable = 1'b1; cyc(1);
    check("restart_flush", 32'(state), 1);
    measure_flush("flush_restart_len");

    wait_state(3, 10);
    PD_flag = 1'b1; cyc(1); PD_flag = 1'b0;
    BD_flag = 1'b1; BD_sgn = 1'b1; cyc(1); BD_flag = 1'b0; BD_sgn = 1'b0;
    check("lock_for_sat", 32'(state), 5);
    rx_data_tvalid = 1'b1; rx_data_tlast = 1'b1;
    cyc(65534);
    check("frame_pre_sat", 32'(frame_cnt), 32'hFFFE);
    cyc(1);
    check("frame_at_sat", 32'(frame_cnt), 32'hFFFF);
    cyc(100);
    check("frame_sat_hold", 32'(frame_cnt), 32'hFFFF);
    rx_data_tvalid = 1'b0; rx_data_tlast = 1'b0;

    #3 rst_n = 1'b0;
    #1;
    check("async_reset",
          {state, rx_chain_rst_n, rx_gate, lock, polarity_inv, err_timeout, frame_cnt, relock_cnt}, 0);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rx_sync_ctrl.md
RX_SYNC_CTRL -- requirements
Module: rx_sync_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 32: cycles rx_chain_rst_n is held low per flush.
REQ-002 Parameter PD_TIMEOUT, default 65536: max cycles in PREAMBLE (2 ms at 32.768 MHz).
REQ-003 Parameter BD_TIMEOUT, default 65536: max cycles in ALIGN.
REQ-004 Parameter SD_LOSS, default 512: consecutive SD_flag-low cycles declaring signal loss.
REQ-005 clk_32M768  in  1  sole clock; all inputs synchronous to it.
REQ-006 rst_n_32M768  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  link enable; low forces IDLE.
REQ-008 SD_flag / PD_flag / BD_flag  in  1 each  signal, preamble and boundary detect levels from Rx.
REQ-009 BD_sgn  in  1  boundary polarity from Rx, valid while BD_flag=1.
REQ-010 rx_data_tvalid / rx_data_tlast  in  1 each  Rx byte stream handshake.
REQ-011 rx_chain_rst_n  out  1  active-low soft reset to the Rx datapath.
REQ-012 rx_gate  out  1  pass-enable for received data.
REQ-013 polarity_inv  out  1  latched BD_sgn.
REQ-014 lock  out  1  high only in LOCKED.
REQ-015 state  out  3  current state code.
REQ-016 frame_cnt  out  16  frames received since last flush.
REQ-017 relock_cnt  out  8  signal-loss events from LOCKED.
REQ-018 err_timeout  out  1  one-cycle pulse on PD or BD timeout.

Function
REQ-019 States and codes: IDLE=0, FLUSH=1, SEARCH=2, PREAMBLE=3, ALIGN=4, LOCKED=5; codes 6-7 return to IDLE on the next cycle.
REQ-020 All outputs are registered and decoded from next-state, so they change on the same edge as state.
REQ-021 IDLE: rx_chain_rst_n=0, rx_gate=0; enable=1 -> FLUSH.
REQ-022 FLUSH: rx_chain_rst_n=0 for exactly FLUSH_CYCLES cycles, then SEARCH; frame_cnt cleared on entry.
REQ-023 SEARCH: no timeout; SD_flag=1 -> PREAMBLE.
REQ-024 PREAMBLE: PD_flag=1 -> ALIGN; dwell timer reaching PD_TIMEOUT -> FLUSH with err_timeout pulse.
REQ-025 ALIGN: BD_flag=1 -> LOCKED, polarity_inv <= BD_sgn on that edge; dwell timer reaching BD_TIMEOUT -> FLUSH with err_timeout pulse.
REQ-026 LOCKED: rx_gate=1, lock=1; frame_cnt +1 on each cycle with rx_data_tvalid & rx_data_tlast, saturating at 0xFFFF.
REQ-027 Signal loss: SD_flag low for SD_LOSS consecutive cycles in PREAMBLE, ALIGN or LOCKED -> FLUSH; the run counter resets on any SD_flag=1 cycle and outside those states.
REQ-028 Loss from LOCKED increments relock_cnt, saturating at 0xFF; relock_cnt clears only on reset.
REQ-029 Priority in one cycle: enable=0 > signal loss > advance flag > timeout; an advance flag coincident with timeout advances without pulsing err_timeout.
REQ-030 Dwell timer: 20-bit, clears on every state change, counts while in PREAMBLE/ALIGN.
REQ-031 enable=0 mid-FLUSH aborts the flush; enable reasserted from IDLE always restarts at FLUSH.
REQ-032 polarity_inv holds its value outside LOCKED until the next ALIGN->LOCKED transition.

Reset
REQ-033 While rst_n_32M768=0: state=IDLE, rx_chain_rst_n=0, rx_gate=0, lock=0, polarity_inv=0, err_timeout=0, all counters and timers 0.
REQ-034 Reset deassertion takes effect on the first clk_32M768 rising edge; first possible FLUSH entry is that edge if enable=1.

Structure
REQ-035 Shared package rx_sync_defs holds the state codes and the default values of FLUSH_CYCLES, PD_TIMEOUT, BD_TIMEOUT, SD_LOSS.
REQ-036 One sub-module, rx_sync_loss_det: consecutive-low counter on SD_flag with a clear input and a loss output; all other logic is in rx_sync_ctrl.

Verification
REQ-037 Reset release, enable=1 -> rx_chain_rst_n low exactly 32 cycles, state=2 on cycle 33.
REQ-038 SD, then PD after 100 cycles, then BD with BD_sgn=1 after 200 cycles -> lock=1, rx_gate=1, polarity_inv=1, state=5.
REQ-039 SD=1, PD never asserted -> err_timeout single pulse at 65536 cycles in PREAMBLE, state=1.
REQ-040 LOCKED, 3 tlast beats then SD low 512 cycles -> frame_cnt=3 before loss, relock_cnt=1, state=1, frame_cnt=0 after the flush.
REQ-041 PD_flag and timer expiry on the same cycle -> state=4, err_timeout stays 0; SD low for 511 cycles then high -> no loss.
REQ-042 enable dropped in LOCKED -> state=0, lock=0, rx_chain_rst_n=0 on the next edge; 70000 tlast beats -> frame_cnt=0xFFFF.
